cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result-bus arbiter between the functional units / LSQ and the wakeup broadcast network of the out-of-order core. Each producer (fu1, fu2, fu3, LSQ forward path) hands a completed result {physical tag, value, ROB index} over a valid/ready handshake. The block buffers one result per producer and grants up to NUM_BUSES producers per cycle, round-robin. Winners drive registered wakeup buses consumed by Rename, ReservationStation, LoadStoreQueue and ReorderBuffer.

## Interface
- NUM_REQ, 4, number of producers (index 0..2 = fu1..fu3, 3 = LSQ)
- NUM_BUSES, 2, number of wakeup broadcast buses (1..NUM_REQ)
- TAG_W, 6, physical tag width
- ROB_W, 6, ROB index width
- DATA_W, 32, result value width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  producer i has a result
- req_tag  in  NUM_REQ*TAG_W  packed, producer i at [i*TAG_W +: TAG_W]
- req_value  in  NUM_REQ*DATA_W  packed result values
- req_rob_index  in  NUM_REQ*ROB_W  packed ROB indices
- req_ready  out  NUM_REQ  producer i's result is accepted this edge if valid
- bus_valid  out  NUM_BUSES  wakeup bus b active
- bus_tag  out  NUM_BUSES*TAG_W  packed
- bus_value  out  NUM_BUSES*DATA_W  packed
- bus_rob_index  out  NUM_BUSES*ROB_W  packed
- bus_src  out  NUM_BUSES*2  producer id driving bus b
- conflict_count  out  32  cycles with more pending slots than buses, saturating

## Operation
- Per producer one holding slot: slot_valid, tag, value, rob_index.
- req_ready[i] = !slot_valid[i] | grant[i] (combinational; same-edge drain and refill allowed).
- Accept: req_valid[i] & req_ready[i] at edge → slot i loaded.
- Arbitration (combinational on slot_valid): scan from rr_ptr upward modulo NUM_REQ; first NUM_BUSES valid slots granted. k-th winner in scan order drives bus k; unused buses get bus_valid=0.
- Granted slot cleared at edge unless refilled the same edge.
- rr_ptr: at each edge with ≥1 grant, rr_ptr ← (last granted index + 1) mod NUM_REQ; unchanged with no grants.
- Bus registers: at edge, bus_valid/tag/value/rob_index/src ← winner data; bus_valid cleared when no winner. Tag/value/rob/src hold last value when invalid (don't-care for consumers).
- conflict_count increments when popcount(slot_valid) > NUM_BUSES; saturates at 32'hFFFF_FFFF.
- No reordering within a producer; no cross-producer ordering guarantee.

## Timing
- Reset (synchronous): all slot_valid=0, bus_valid=0, bus_tag/value/rob_index/bus_src=0, rr_ptr=0, conflict_count=0; req_ready all 1 in the cycle after. Reset mid-operation discards buffered results.
- Latency: accepted at edge E0 → visible on bus after edge E1 (1 cycle in slot), if uncontended.
- Throughput: one result per producer per cycle when uncontended.
- Starvation bound: pending slot granted within ceil(NUM_REQ/NUM_BUSES) edges (2 for defaults).
- Full: slot valid and not granted → req_ready[i]=0; producer holds its data (FU must stall, is_available low).

## Structure
- Shared package/header: TAG_W, ROB_W, DATA_W, producer id constants (FU1=0, FU2=1, FU3=2, LSQ=3).
- Sub-module rr_picker: combinational rotating priority selector returning up to NUM_BUSES one-hot grants plus their indices from a request vector and rr_ptr; instantiated once.
- Top-level instantiation replaces direct FU→wakeup wiring; wakeup_0..3 map to buses when NUM_BUSES=4.

## Test plan
- After reset, producer 0 presents tag 5, value 0x1234, rob 3 for one cycle → after next edge bus0 = {5, 0x1234, 3, src 0}, bus_valid=2'b01; req_ready stays 4'b1111.
- All four valid same cycle, rr_ptr=0 → first bus cycle: bus0=src0, bus1=src1; second: bus0=src2, bus1=src3; conflict_count=1; req_ready[3:2]=0 for exactly one cycle.
- Producer 1 streams 8 results back-to-back, others idle → bus0 carries them on 8 consecutive cycles in order, req_ready[1] never 0.
- All four held valid continuously for 20 cycles → every producer granted exactly every 2nd cycle, no gap >2, conflict_count increments each cycle with >2 pending.
- NUM_BUSES=1, four simultaneous results → drained one per cycle in order 0,1,2,3, bus_src 0,1,2,3.
- Reset asserted with slots 0, 2, 3 full → next cycle bus_valid=0, req_ready=4'b1111, conflict_count=0; prior results never broadcast.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, producer ids and the result payload for the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;

  // Producer ids as seen on bus_src.
  localparam logic [SRC_W-1:0] SRC_FU1 = 2'd0;
  localparam logic [SRC_W-1:0] SRC_FU2 = 2'd1;
  localparam logic [SRC_W-1:0] SRC_FU3 = 2'd2;
  localparam logic [SRC_W-1:0] SRC_LSQ = 2'd3;

  // One completed result as held in a producer slot.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [ROB_W-1:0]  rob_index;
  } result_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Rotating-priority selector: scans requests from i_ptr upward (mod NUM_REQ)
// and picks the first NUM_BUSES set bits.
//   i_req       request vector (pending slots)
//   i_ptr       scan start index
//   o_grant     one-hot-per-winner grant vector
//   o_sel_valid bus k has a winner
//   o_sel_idx   index of the k-th winner, packed per bus
//   o_last_idx  index of the last winner in scan order
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BUSES = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [SRC_W-1:0]           i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_BUSES-1:0]       o_sel_valid,
  output logic [NUM_BUSES*SRC_W-1:0] o_sel_idx,
  output logic [SRC_W-1:0]           o_last_idx
);

  // n_sel counts winners found so far; the k-th winner lands on bus k.
  always_comb begin
    int unsigned      n_sel;
    logic [SRC_W-1:0] idx;
    o_grant     = '0;
    o_sel_valid = '0;
    o_sel_idx   = '0;
    o_last_idx  = '0;
    n_sel       = 0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((32'(i_ptr) + k) % NUM_REQ);
      if (i_req[idx]) begin
        for (int unsigned b = 0; b < NUM_BUSES; b++) begin
          if (n_sel == b) begin
            o_grant[idx]                   = 1'b1;
            o_sel_valid[b]                 = 1'b1;
            o_sel_idx[b*SRC_W +: SRC_W]    = idx;
            o_last_idx                     = idx;
          end
        end
        n_sel++;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: one holding slot per producer, up to NUM_BUSES
// round-robin grants per cycle onto registered wakeup buses.
//   clk, reset         clock, synchronous active-high reset
//   req_*              producer handshake and packed result payloads
//   req_ready          slot free or draining this cycle
//   bus_*              registered wakeup broadcast buses
//   conflict_count     saturating count of cycles with more pending than buses
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BUSES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  input  logic [NUM_REQ*ROB_W-1:0]    req_rob_index,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_BUSES-1:0]        bus_valid,
  output logic [NUM_BUSES*TAG_W-1:0]  bus_tag,
  output logic [NUM_BUSES*DATA_W-1:0] bus_value,
  output logic [NUM_BUSES*ROB_W-1:0]  bus_rob_index,
  output logic [NUM_BUSES*SRC_W-1:0]  bus_src,
  output logic [31:0]                 conflict_count
);

  logic [NUM_REQ-1:0]         r_slot_valid;
  result_t                    r_slot [NUM_REQ];
  logic [SRC_W-1:0]           r_rr_ptr;

  logic [NUM_REQ-1:0]         w_grant;
  logic [NUM_BUSES-1:0]       w_sel_valid;
  logic [NUM_BUSES*SRC_W-1:0] w_sel_idx;
  logic [SRC_W-1:0]           w_last_idx;
  logic                       w_conflict;

  cdb_arbiter_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_BUSES (NUM_BUSES)
  ) u_picker (
    .i_req       (r_slot_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_sel_valid (w_sel_valid),
    .o_sel_idx   (w_sel_idx),
    .o_last_idx  (w_last_idx)
  );

  // A granted slot empties at this edge, so it may be refilled at the same edge.
  assign req_ready  = ~r_slot_valid | w_grant;
  assign w_conflict = 32'($countones(r_slot_valid)) > NUM_BUSES;

  // Slots, wakeup buses, round-robin pointer and conflict counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid   <= '0;
      r_rr_ptr       <= '0;
      conflict_count <= '0;
      bus_valid      <= '0;
      bus_tag        <= '0;
      bus_value      <= '0;
      bus_rob_index  <= '0;
      bus_src        <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_slot[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          r_slot_valid[i]     <= 1'b1;
          r_slot[i].tag       <= req_tag[i*TAG_W +: TAG_W];
          r_slot[i].value     <= req_value[i*DATA_W +: DATA_W];
          r_slot[i].rob_index <= req_rob_index[i*ROB_W +: ROB_W];
        end else if (w_grant[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end

      // Payload fields hold their last value when a bus goes idle.
      for (int unsigned b = 0; b < NUM_BUSES; b++) begin
        bus_valid[b] <= w_sel_valid[b];
        if (w_sel_valid[b]) begin
          bus_tag[b*TAG_W +: TAG_W]       <= r_slot[w_sel_idx[b*SRC_W +: SRC_W]].tag;
          bus_value[b*DATA_W +: DATA_W]   <= r_slot[w_sel_idx[b*SRC_W +: SRC_W]].value;
          bus_rob_index[b*ROB_W +: ROB_W] <= r_slot[w_sel_idx[b*SRC_W +: SRC_W]].rob_index;
          bus_src[b*SRC_W +: SRC_W]       <= w_sel_idx[b*SRC_W +: SRC_W];
        end
      end

      if (|w_grant) r_rr_ptr <= SRC_W'((32'(w_last_idx) + 1) % NUM_REQ);

      if (w_conflict && (conflict_count != 32'hFFFF_FFFF))
        conflict_count <= conflict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int NB  = 2;
  localparam int NB1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR*TAG_W-1:0]    req_tag;
  logic [NR*DATA_W-1:0]   req_value;
  logic [NR*ROB_W-1:0]    req_rob_index;
  logic [NR-1:0]          req_ready;
  logic [NB-1:0]          bus_valid;
  logic [NB*TAG_W-1:0]    bus_tag;
  logic [NB*DATA_W-1:0]   bus_value;
  logic [NB*ROB_W-1:0]    bus_rob_index;
  logic [NB*SRC_W-1:0]    bus_src;
  logic [31:0]            conflict_count;

  // Single-bus instance for the serialised-drain scenario.
  logic [NR-1:0]          req_valid1;
  logic [NR*TAG_W-1:0]    req_tag1;
  logic [NR*DATA_W-1:0]   req_value1;
  logic [NR*ROB_W-1:0]    req_rob_index1;
  logic [NR-1:0]          req_ready1;
  logic [NB1-1:0]         bus_valid1;
  logic [NB1*TAG_W-1:0]   bus_tag1;
  logic [NB1*DATA_W-1:0]  bus_value1;
  logic [NB1*ROB_W-1:0]   bus_rob_index1;
  logic [NB1*SRC_W-1:0]   bus_src1;
  logic [31:0]            conflict_count1;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_BUSES(NB)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_value(req_value), .req_rob_index(req_rob_index), .req_ready(req_ready),
    .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_value(bus_value),
    .bus_rob_index(bus_rob_index), .bus_src(bus_src), .conflict_count(conflict_count)
  );

  cdb_arbiter #(.NUM_REQ(NR), .NUM_BUSES(NB1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_tag(req_tag1),
    .req_value(req_value1), .req_rob_index(req_rob_index1), .req_ready(req_ready1),
    .bus_valid(bus_valid1), .bus_tag(bus_tag1), .bus_value(bus_value1),
    .bus_rob_index(bus_rob_index1), .bus_src(bus_src1), .conflict_count(conflict_count1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the 2-bus instance ----------------
  logic              m_v    [NR];
  result_t           m_s    [NR];
  int                m_age  [NR];
  int                m_ptr;
  logic [31:0]       m_cnt;
  logic              m_bv   [NB];
  result_t           m_bres [NB];
  int                m_bsrc [NB];
  int                m_win  [NB];
  logic [NR-1:0]     m_acc;
  result_t           sb_q   [NR][$];

  // First NB pending producers in rotating order from m_ptr.
  task automatic m_arbitrate();
    int n;
    n = 0;
    for (int b = 0; b < NB; b++) m_win[b] = -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (m_v[i] && n < NB) begin
        m_win[n] = i;
        n++;
      end
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NR; i++) begin
      m_v[i] = 1'b0; m_s[i] = '0; m_age[i] = 0; sb_q[i].delete();
    end
    for (int b = 0; b < NB; b++) begin
      m_bv[b] = 1'b0; m_bres[b] = '0; m_bsrc[b] = 0;
    end
    m_ptr = 0;
    m_cnt = '0;
  endtask

  // One clock cycle: check handshake, advance the model over the edge, check outputs.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] granted;
    int            npend;
    int            last;
    #1;
    m_arbitrate();
    granted = '0;
    for (int b = 0; b < NB; b++) if (m_win[b] >= 0) granted[m_win[b]] = 1'b1;
    npend = 0;
    for (int i = 0; i < NR; i++) begin
      exp_rdy[i] = !m_v[i] || granted[i];
      if (m_v[i]) npend++;
    end
    if (!reset) chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    m_acc = reset ? '0 : (req_valid & exp_rdy);

    @(posedge clk);
    #1;
    if (reset) begin
      m_clear();
    end else begin
      last = -1;
      for (int b = 0; b < NB; b++) begin
        if (m_win[b] >= 0) begin
          m_bv[b]   = 1'b1;
          m_bres[b] = m_s[m_win[b]];
          m_bsrc[b] = m_win[b];
          last      = m_win[b];
        end else begin
          m_bv[b] = 1'b0;
        end
      end
      if (last >= 0) m_ptr = (last + 1) % NR;
      if (npend > NB && m_cnt != 32'hFFFF_FFFF) m_cnt++;

      // In-order delivery per producer, checked from the DUT's own broadcasts.
      for (int b = 0; b < NB; b++) begin
        if (bus_valid[b]) begin
          int src;
          result_t got;
          src = int'(bus_src[b*SRC_W +: SRC_W]);
          got.tag       = bus_tag[b*TAG_W +: TAG_W];
          got.value     = bus_value[b*DATA_W +: DATA_W];
          got.rob_index = bus_rob_index[b*ROB_W +: ROB_W];
          if (sb_q[src].size() == 0) chk("order_unexpected", 64'(got), 64'(0));
          else chk("order", 64'(got), 64'(sb_q[src].pop_front()));
        end
      end

      for (int i = 0; i < NR; i++) begin
        if (m_v[i] && granted[i]) begin
          chk("starvation_age", 64'(m_age[i] <= 1), 64'(1));
          m_v[i] = 1'b0;
        end else if (m_v[i]) begin
          m_age[i]++;
        end
        if (m_acc[i]) begin
          m_v[i]           = 1'b1;
          m_age[i]         = 0;
          m_s[i].tag       = req_tag[i*TAG_W +: TAG_W];
          m_s[i].value     = req_value[i*DATA_W +: DATA_W];
          m_s[i].rob_index = req_rob_index[i*ROB_W +: ROB_W];
          sb_q[i].push_back(m_s[i]);
        end
      end
    end

    for (int b = 0; b < NB; b++) begin
      chk("bus_valid", 64'(bus_valid[b]), 64'(m_bv[b]));
      chk("bus_tag",   64'(bus_tag[b*TAG_W +: TAG_W]), 64'(m_bres[b].tag));
      chk("bus_value", 64'(bus_value[b*DATA_W +: DATA_W]), 64'(m_bres[b].value));
      chk("bus_rob",   64'(bus_rob_index[b*ROB_W +: ROB_W]), 64'(m_bres[b].rob_index));
      chk("bus_src",   64'(bus_src[b*SRC_W +: SRC_W]), 64'(m_bsrc[b]));
    end
    chk("conflict_count", 64'(conflict_count), 64'(m_cnt));
  endtask

  task automatic set_req(input int i, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] v, input logic [ROB_W-1:0] r);
    req_tag[i*TAG_W +: TAG_W]       = t;
    req_value[i*DATA_W +: DATA_W]   = v;
    req_rob_index[i*ROB_W +: ROB_W] = r;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Random producers: each holds its result until accepted.
  logic p_has [NR];

  task automatic random_cycles(input int n, input int pct);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p_has[i] && int'($urandom_range(99)) < pct) begin
          p_has[i] = 1'b1;
          set_req(i, TAG_W'($urandom), $urandom, ROB_W'($urandom));
        end
        req_valid[i] = p_has[i];
      end
      step();
      for (int i = 0; i < NR; i++) if (m_acc[i]) p_has[i] = 1'b0;
    end
  endtask

  int seen [NR];

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_tag        = '0;
    req_value      = '0;
    req_rob_index  = '0;
    req_valid1     = '0;
    req_tag1       = '0;
    req_value1     = '0;
    req_rob_index1 = '0;
    m_clear();
    for (int i = 0; i < NR; i++) p_has[i] = 1'b0;

    // Reset state.
    do_reset();
    chk("rst_bus_valid", 64'(bus_valid), 64'(0));
    chk("rst_conflict", 64'(conflict_count), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(4'hF));

    // Single uncontended result from producer 0.
    req_valid = 4'b0001;
    set_req(0, 6'd5, 32'h1234, 6'd3);
    step();
    req_valid = '0;
    chk("single_ready", 64'(req_ready), 64'(4'hF));
    step();
    chk("single_bv", 64'(bus_valid), 64'(2'b01));
    chk("single_tag", 64'(bus_tag[5:0]), 64'(6'd5));
    chk("single_val", 64'(bus_value[31:0]), 64'(32'h1234));
    chk("single_rob", 64'(bus_rob_index[5:0]), 64'(6'd3));
    chk("single_src", 64'(bus_src[1:0]), 64'(2'd0));

    // All four at once: two drain per cycle, 0/1 then 2/3.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_req(i, TAG_W'(10 + i), DATA_W'(32'hA0 + i), ROB_W'(20 + i));
    step();
    req_valid = '0;
    #1;
    chk("all4_ready_e1", 64'(req_ready), 64'(4'b0011));
    step();
    chk("all4_src_e1", 64'(bus_src), 64'(4'b0100));
    chk("all4_tag0_e1", 64'(bus_tag[5:0]), 64'(6'd10));
    chk("all4_tag1_e1", 64'(bus_tag[11:6]), 64'(6'd11));
    chk("all4_conf_e1", 64'(conflict_count), 64'(1));
    chk("all4_ready_e2", 64'(req_ready), 64'(4'hF));
    step();
    chk("all4_src_e2", 64'(bus_src), 64'(4'b1110));
    chk("all4_val1_e2", 64'(bus_value[63:32]), 64'(32'hA3));
    chk("all4_conf_e2", 64'(conflict_count), 64'(1));
    step();
    chk("all4_idle", 64'(bus_valid), 64'(0));

    // Producer 1 streams 8 back-to-back results.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      req_valid = 4'b0010;
      set_req(1, TAG_W'(30 + j), DATA_W'(j), ROB_W'(j));
      #1;
      chk("stream_ready", 64'(req_ready[1]), 64'(1));
      step();
      if (j > 0) chk("stream_tag", 64'(bus_tag[5:0]), 64'(30 + j - 1));
    end
    req_valid = '0;
    step();
    chk("stream_last_tag", 64'(bus_tag[5:0]), 64'(6'd37));
    chk("stream_last_src", 64'(bus_src[1:0]), 64'(2'd1));

    // All four held valid for 20 cycles.
    do_reset();
    for (int i = 0; i < NR; i++) begin p_has[i] = 1'b0; seen[i] = 0; end
    for (int c = 0; c < 20; c++) begin
      random_cycles(1, 100);
      for (int b = 0; b < NB; b++)
        if (bus_valid[b]) seen[int'(bus_src[b*SRC_W +: SRC_W])]++;
    end
    chk("sat_conflict", 64'(conflict_count), 64'(19));
    chk("sat_seen0", 64'(seen[0]), 64'(10));
    chk("sat_seen1", 64'(seen[1]), 64'(10));
    chk("sat_seen2", 64'(seen[2]), 64'(9));
    chk("sat_seen3", 64'(seen[3]), 64'(9));

    // Single-bus instance drains 0,1,2,3 in order.
    do_reset();
    req_valid1 = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      req_tag1[i*TAG_W +: TAG_W]     = TAG_W'(40 + i);
      req_value1[i*DATA_W +: DATA_W] = DATA_W'(100 + i);
      req_rob_index1[i*ROB_W +: ROB_W] = ROB_W'(i);
    end
    step();
    req_valid1 = '0;
    #1;
    chk("nb1_ready", 64'(req_ready1), 64'(4'b0001));
    for (int k = 0; k < NR; k++) begin
      step();
      chk("nb1_valid", 64'(bus_valid1), 64'(1));
      chk("nb1_src", 64'(bus_src1), 64'(k));
      chk("nb1_tag", 64'(bus_tag1), 64'(40 + k));
    end
    chk("nb1_conflict", 64'(conflict_count1), 64'(3));

    // Reset with slots 0,2,3 full discards them.
    do_reset();
    req_valid = 4'b1101;
    for (int i = 0; i < NR; i++) set_req(i, TAG_W'(50 + i), DATA_W'(i), ROB_W'(i));
    step();
    req_valid = '0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_bv", 64'(bus_valid), 64'(0));
    chk("midrst_conf", 64'(conflict_count), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(4'hF));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_quiet", 64'(bus_valid), 64'(0));
    end

    // Randomized traffic at several loads, with one reset in the middle.
    do_reset();
    for (int i = 0; i < NR; i++) p_has[i] = 1'b0;
    random_cycles(60, 15);
    random_cycles(60, 45);
    reset = 1'b1;
    random_cycles(1, 50);
    reset = 1'b0;
    random_cycles(60, 75);
    random_cycles(60, 100);
    random_cycles(60, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
